// File: rtl/div16_restoring.sv
// div16_restoring: restoring unsigned divider, one quotient bit per clock; DIV16_ZERO_FAST_EN short-circuits divide-by-zero.
// Latency: start at edge k -> done during the cycle after edge k+WIDTH (after edge k with a zero divisor in the fast build).
// Backpressure: none; start is sampled only in IDLE, so back-to-back ops issue every WIDTH+2 cycles.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module div16_restoring #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] trial;
  logic [WIDTH:0]   carry;
  logic             no_borrow;

  assign r_shift  = {r_q, q_q[WIDTH-1]};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    fulladder u_fa (
      .a_i (r_shift[i]),
      .b_i (~dvs_q[i]),
      .ci_i(carry[i]),
      .s_o (trial[i]),
      .co_o(carry[i+1])
    );
  end

  // A set top bit means the shifted remainder already exceeds any WIDTH-bit divisor.
  assign no_borrow = carry[WIDTH] | r_shift[WIDTH];

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = dividend;
          r_d     = '0;
          dvs_d   = divisor;
          cnt_d   = '0;
          dz_d    = (divisor == '0);
          state_d = RUN;
`ifdef DIV16_ZERO_FAST_EN
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        q_d   = {q_q[WIDTH-2:0], no_borrow};
        r_d   = no_borrow ? trial : r_shift[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          quot_d  = q_d;
          rem_d   = r_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
endmodule

// File: tb/tb_div16_restoring.sv
// Randomised and directed bench for div16_restoring against a / and % reference model.
`timescale 1ns/1ps
module tb_div16_restoring;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  div16_restoring #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? {W{1'b1}} : a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? a : a % b;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
`ifdef DIV16_ZERO_FAST_EN
    if (b == '0) return 1;
`endif
    return W + 1;
  endfunction

  function automatic int ref_busy(input logic [W-1:0] b);
`ifdef DIV16_ZERO_FAST_EN
    if (b == '0) return 0;
`endif
    return W;
  endfunction

  // Ends at the falling edge just after the accepting rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 0; nb = 0;
    while (!done && n < 60) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int n, nb;
    issue(a, b);
    wait_done(n, nb);
    check({tag, "_lat"}, 1 + n, ref_lat(b));
    check({tag, "_busy_cyc"}, nb, ref_busy(b));
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_q"}, quotient, ref_q(a, b));
    check({tag, "_r"}, remainder, ref_r(a, b));
    check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, b == '0});
  endtask

  initial begin
    int n, nb, seen;
    logic [W-1:0] ta[3];
    logic [W-1:0] tb_[3];
    logic [W-1:0] a, b;

    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    do_op("d100_7", 16'd100, 16'd7);
    do_op("ffff_1", 16'hFFFF, 16'd1);
    do_op("d5_9", 16'd5, 16'd9);
    do_op("d0_3", 16'd0, 16'd3);
    do_op("d1234_0", 16'h1234, 16'd0);

    // Mid-run start pulse must not disturb the op in flight.
    @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd99; divisor = 16'd2;
    @(negedge clk); start = 1'b0;
    wait_done(n, nb);
    check("ign_lat", 6 + n, W + 1);
    check("ign_q", quotient, 32'd10);
    check("ign_r", remainder, 32'd0);
    repeat (5) @(negedge clk);
    check("hold_done", {31'd0, done}, 32'd0);
    check("hold_busy", {31'd0, busy}, 32'd0);
    check("hold_q", quotient, 32'd10);
    check("hold_r", remainder, 32'd0);

    // Reset in the middle of an iteration run.
    issue(16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_q", quotient, 32'd0);
    check("mrst_r", remainder, 32'd0);
    check("mrst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("mrst_no_done", seen, 32'd0);
    do_op("d1000_3", 16'd1000, 16'd3);

    // start held high across three ops.
    ta[0] = 16'd1234;  tb_[0] = 16'd7;
    ta[1] = 16'd60000; tb_[1] = 16'd255;
    ta[2] = 16'd777;   tb_[2] = 16'd1;
    @(negedge clk);
    start = 1'b1; dividend = ta[0]; divisor = tb_[0];
    for (int i = 0; i < 3; i++) begin
      wait_done(n, nb);
      check($sformatf("b2b%0d_gap", i), (i == 0) ? n : n + 1, (i == 0) ? W + 1 : W + 2);
      check($sformatf("b2b%0d_q", i), quotient, ref_q(ta[i], tb_[i]));
      check($sformatf("b2b%0d_r", i), remainder, ref_r(ta[i], tb_[i]));
      if (i < 2) begin
        dividend = ta[i+1]; divisor = tb_[i+1];
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end

    for (int k = 0; k < 1000; k++) begin
      a = W'($urandom);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2, 3: b = W'($urandom_range(1, 15));
        4:       begin b = W'($urandom); a = W'($urandom_range(0, 255)); end
        default: b = W'($urandom);
      endcase
      do_op($sformatf("rnd%0d", k), a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
